// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with valid/ready handshake on both sides.
// The operands are split into STAGES equal chunks; stage k adds chunk k and
// hands its carry to stage k+1. Operand chunks not yet consumed travel in
// skew registers, and finished low chunks of the sum travel alongside them.
// The whole pipe freezes as one when the consumer back-pressures.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CW = WIDTH / STAGES;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Chunk adder: CW-bit add with carry-in, carry-out in the top bit.
  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          ci);
    add_chunk = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
  endfunction

  // Two's-complement overflow from the sign bits of both addends and the result.
  function automatic logic ovf_flag(input logic a_sign,
                                    input logic b_sign,
                                    input logic s_sign);
    ovf_flag = (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

  // A stalled output freezes everything; in_ready never looks at in_valid.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Subtraction is A + ~B + 1; the carry-in is ignored in that case.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_sub | in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still pending at the input of this stage (chunk k and up).
    localparam int OPW = WIDTH - k * CW;

    logic [OPW-1:0]        a_in;
    logic [OPW-1:0]        b_in;
    logic                  c_in;
    logic                  v_in;
    logic [CW:0]           chunk;
    logic [(k+1)*CW-1:0]   s_nxt;
    logic                  vld_p;
    logic                  c_p;
    logic [(k+1)*CW-1:0]   s_p;

    if (k == 0) begin : g_head
      assign a_in  = in_a;
      assign b_in  = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign s_nxt = chunk[CW-1:0];
    end else begin : g_link
      assign a_in  = g_stage[k-1].g_skew.a_p;
      assign b_in  = g_stage[k-1].g_skew.b_p;
      assign c_in  = g_stage[k-1].c_p;
      assign v_in  = g_stage[k-1].vld_p;
      assign s_nxt = {chunk[CW-1:0], g_stage[k-1].s_p};
    end

    assign chunk = add_chunk(a_in[CW-1:0], b_in[CW-1:0], c_in);

    // ---- stage k register: valid, carry and the sum chunks finished so far
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        c_p   <= 1'b0;
        s_p   <= '0;
      end else if (!stall) begin
        vld_p <= v_in;
        c_p   <= chunk[CW];
        s_p   <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [OPW-CW-1:0] a_p;
      logic [OPW-CW-1:0] b_p;

      // Skew registers: carry the not-yet-added upper operand chunks forward.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (!stall) begin
          a_p <= a_in[OPW-1:CW];
          b_p <= b_in[OPW-1:CW];
        end
      end
    end else begin : g_tail
      logic ovf_p;
      logic zero_p;

      // Final-stage flags, registered together with the assembled sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p  <= 1'b0;
          zero_p <= 1'b0;
        end else if (!stall) begin
          ovf_p  <= ovf_flag(a_in[OPW-1], b_in[OPW-1], chunk[CW-1]);
          zero_p <= (s_nxt == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_p;
  assign out_sum   = g_stage[STAGES-1].s_p;
  assign out_cout  = g_stage[STAGES-1].c_p;
  assign out_ovf   = g_stage[STAGES-1].g_tail.ovf_p;
  assign out_zero  = g_stage[STAGES-1].g_tail.zero_p;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: literal directed vectors, a streaming
// run under toggling back-pressure, and a mid-flight reset, all watched by an
// arithmetic reference model with an in-order expectation queue.
module tb_pipe_adder;
  parameter int STAGES = 2;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  int total = 0;
  int bad   = 0;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc_cyc;
    int          stall_at;
  } exp_t;

  exp_t q[$];

  // Reference: plain wide integer arithmetic, signed range check for overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    exp_t  e;
    longint ua, ub, sa, sb, u, t;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (sub) begin
      u      = ua - ub;
      t      = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      u      = ua + ub + {63'd0, cin};
      t      = sa + sb + {63'd0, cin};
      e.cout = (u > 64'sh0FFFF_FFFF);
    end
    e.sum      = u[31:0];
    e.ovf      = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    e.zero     = (e.sum == 32'd0);
    e.acc_cyc  = 0;
    e.stall_at = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  int          cyc = 0;
  int          stalls = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] h_sum;
  logic        h_cout, h_ovf, h_zero;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      cyc++;
      total++;
      if (in_ready !== ~(out_valid & ~out_ready)) begin
        bad++;
        $display("FAIL in_ready: got %b, out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (prev_stall) begin
        total++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== {1'b1, h_sum, h_cout, h_ovf, h_zero}) begin
          bad++;
          $display("FAIL hold: got v=%b sum=%h, want v=1 sum=%h", out_valid, out_sum, h_sum);
        end
      end
      if (out_valid && q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious: out_valid=1 sum=%h, want no beat", out_sum);
      end else if (out_valid && out_ready) begin
        e = q.pop_front();
        total++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
          bad++;
          $display("FAIL result: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                   out_sum, out_cout, out_ovf, out_zero, e.sum, e.cout, e.ovf, e.zero);
        end
        total++;
        if (cyc != e.acc_cyc + STAGES + (stalls - e.stall_at)) begin
          bad++;
          $display("FAIL latency: got cycle %0d, want %0d", cyc, e.acc_cyc + STAGES + (stalls - e.stall_at));
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_a, in_b, in_sub, in_cin);
        e.acc_cyc  = cyc;
        e.stall_at = stalls;
        q.push_back(e);
      end
      prev_stall = out_valid & ~out_ready;
      if (prev_stall) begin
        stalls++;
        h_sum  = out_sum;
        h_cout = out_cout;
        h_ovf  = out_ovf;
        h_zero = out_zero;
      end
    end
  end

  // One beat with literal expected results and latency.
  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic cin, input logic [31:0] es,
                     input logic ec, input logic eo, input logic ez);
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < STAGES + 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".lat"},  64'(n), 64'(STAGES));
    chk({nm, ".sum"},  64'(out_sum), 64'(es));
    chk({nm, ".cout"}, 64'(out_cout), 64'(ec));
    chk({nm, ".ovf"},  64'(out_ovf), 64'(eo));
    chk({nm, ".zero"}, 64'(out_zero), 64'(ez));
  endtask

  task automatic load_random();
    logic [31:0] r;
    r = $urandom;
    in_a   = $urandom;
    in_b   = $urandom;
    in_sub = r[0];
    in_cin = r[1];
  endtask

  // Continuous in_valid with out_ready toggling every cycle.
  task automatic stream(input int nbeats);
    int   sent = 0;
    int   guard = 0;
    logic acc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    load_random();
    while (sent < nbeats && guard < 400) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      out_ready = ~out_ready;
      if (acc) begin
        sent++;
        load_random();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream.sent", 64'(sent), 64'(nbeats));
  endtask

  task automatic drain(input string nm);
    int g = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk); #1;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.flags", 64'({out_sum, out_cout, out_ovf, out_zero}), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    lit("add_carry",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    lit("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    lit("add_wrap",   32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    lit("sub_eq",     32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    lit("sub_cinign", 32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    lit("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    lit("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    drain("drain.lit");

    stream(16);
    drain("drain.stream");

    // Two beats in flight, then an asynchronous reset between clock edges.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 32'h00001234; in_b = 32'h00000001; in_sub = 1'b0; in_cin = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h0000FFFF; in_b = 32'h0000FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(out_valid), 64'd0);
    chk("midrst.flags", 64'({out_sum, out_cout, out_ovf, out_zero}), 64'd0);
    chk("midrst.ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("postrst.valid", 64'(out_valid), 64'd0);
    end

    lit("after_rst", 32'h00000003, 32'h00000004, 1'b0, 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b0);
    drain("drain.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
